// File: rtl/rpn_stack_ctrl.sv
// RPN token sequencer driving an external LIFO: pushes operands, pops two words
// per operator, computes a op b and pushes the result back.
module rpn_stack_ctrl #(
   parameter int DW    = 4,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tok_valid,
   output logic                     tok_ready,
   input  logic                     tok_is_op,
   input  logic [1:0]               tok_op,
   input  logic [DW-1:0]            tok_data,
   output logic                     stk_push,
   output logic                     stk_pop,
   output logic [DW-1:0]            stk_din,
   input  logic [DW-1:0]            stk_dout,
   output logic [DW-1:0]            result,
   output logic                     result_vld,
   output logic [$clog2(DEPTH):0]   depth,
   output logic                     err_under,
   output logic                     err_over,
   input  logic                     err_clr
);

   localparam int AW = $clog2(DEPTH) + 1;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] PUSH  = 3'd1;
   localparam logic [2:0] POP_B = 3'd2;
   localparam logic [2:0] CAP_B = 3'd3;
   localparam logic [2:0] POP_A = 3'd4;
   localparam logic [2:0] CAP_A = 3'd5;
   localparam logic [2:0] EXEC  = 3'd6;

   localparam logic [AW-1:0] FULL = AW'(DEPTH);
   localparam logic [AW-1:0] TWO  = AW'(2);
   localparam logic [AW-1:0] ONE  = AW'(1);

   logic [2:0]    state;
   logic [1:0]    op_r;
   logic [DW-1:0] a_r;
   logic [DW-1:0] b_r;
   logic [DW-1:0] alu;
   logic          from_op;
   logic          accept;
   logic          set_under;
   logic          set_over;

   assign tok_ready  = (state == IDLE);
   assign stk_push   = (state == PUSH);
   assign stk_pop    = (state == POP_B) || (state == POP_A);
   assign result_vld = (state == PUSH) && from_op;
   assign accept     = tok_valid && tok_ready;
   assign set_under  = accept && tok_is_op && (depth < TWO);
   assign set_over   = accept && !tok_is_op && (depth == FULL);

   always_comb begin
      alu = '0;
      case (op_r)
         2'b00:   alu = a_r + b_r;
         2'b01:   alu = a_r - b_r;
         2'b10:   alu = a_r & b_r;
         default: alu = a_r ^ b_r;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         depth     <= '0;
         result    <= '0;
         stk_din   <= '0;
         op_r      <= '0;
         a_r       <= '0;
         b_r       <= '0;
         from_op   <= 1'b0;
         err_under <= 1'b0;
         err_over  <= 1'b0;
      end else begin
         // Setting an error takes priority over a simultaneous clear.
         err_under <= set_under || (err_under && !err_clr);
         err_over  <= set_over  || (err_over  && !err_clr);
         case (state)
            IDLE: begin
               from_op <= 1'b0;
               if (accept) begin
                  if (tok_is_op) begin
                     if (!set_under) begin
                        op_r  <= tok_op;
                        state <= POP_B;
                     end
                  end else if (!set_over) begin
                     stk_din <= tok_data;
                     state   <= PUSH;
                  end
               end
            end
            PUSH: begin
               depth <= depth + ONE;
               state <= IDLE;
            end
            POP_B: begin
               depth <= depth - ONE;
               state <= CAP_B;
            end
            CAP_B: begin
               b_r   <= stk_dout;
               state <= POP_A;
            end
            POP_A: begin
               depth <= depth - ONE;
               state <= CAP_A;
            end
            CAP_A: begin
               a_r   <= stk_dout;
               state <= EXEC;
            end
            EXEC: begin
               result  <= alu;
               stk_din <= alu;
               from_op <= 1'b1;
               state   <= PUSH;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Directed bench for rpn_stack_ctrl with a behavioural 8-deep LIFO attached.
module tb_rpn_stack_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tok_valid;
   logic       tok_ready;
   logic       tok_is_op;
   logic [1:0] tok_op;
   logic [3:0] tok_data;
   logic       stk_push;
   logic       stk_pop;
   logic [3:0] stk_din;
   logic [3:0] stk_dout;
   logic [3:0] result;
   logic       result_vld;
   logic [3:0] depth;
   logic       err_under;
   logic       err_over;
   logic       err_clr;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rpn_stack_ctrl #(.DW(4), .DEPTH(8)) dut (
      .clk(clk), .rst(rst),
      .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_is_op(tok_is_op), .tok_op(tok_op), .tok_data(tok_data),
      .stk_push(stk_push), .stk_pop(stk_pop),
      .stk_din(stk_din), .stk_dout(stk_dout),
      .result(result), .result_vld(result_vld),
      .depth(depth), .err_under(err_under), .err_over(err_over),
      .err_clr(err_clr)
   );

   // Attached LIFO: pop data appears the cycle after the pop strobe.
   logic [3:0] mem [8];
   int         sp;
   always @(posedge clk) begin
      if (rst) begin
         sp <= 0;
      end else begin
         if (stk_push && sp < 8) begin
            mem[sp] <= stk_din;
            sp      <= sp + 1;
         end
         if (stk_pop && sp > 0) begin
            stk_dout <= mem[sp-1];
            sp       <= sp - 1;
         end
      end
   end

   always @(negedge clk) begin
      total++;
      if (stk_push && stk_pop) begin
         bad++;
         $display("FAIL push_pop_overlap: push=%0b pop=%0b required not both", stk_push, stk_pop);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   typedef struct {
      logic       is_op;
      logic [1:0] op;
      logic [3:0] data;
      logic       clr;
      logic [3:0] e_res;
      int         e_depth;
      logic       e_eu;
      logic       e_eo;
      int         e_rdy;
      int         e_vld;
      int         e_push;
      int         e_pop;
   } vec_t;

   vec_t vt [30];

   task automatic setv(input int i, input logic is_op, input logic [1:0] op,
                       input logic [3:0] data, input logic clr, input logic [3:0] res,
                       input int dep, input logic eu, input logic eo, input int rdy,
                       input int vld, input int psh, input int pp);
      vt[i].is_op = is_op;  vt[i].op = op;       vt[i].data = data;  vt[i].clr = clr;
      vt[i].e_res = res;    vt[i].e_depth = dep; vt[i].e_eu = eu;    vt[i].e_eo = eo;
      vt[i].e_rdy = rdy;    vt[i].e_vld = vld;   vt[i].e_push = psh; vt[i].e_pop = pp;
   endtask

   // Called #1 after a posedge with DUT in IDLE; returns per-cycle observations.
   task automatic run_tok(input logic is_op, input logic [1:0] op, input logic [3:0] data,
                          input logic clr, output int rdy_k, output int vld_k,
                          output int pushes, output int pops);
      chk("ready_before_token", int'(tok_ready), 1);
      tok_valid = 1'b1; tok_is_op = is_op; tok_op = op; tok_data = data; err_clr = clr;
      @(posedge clk); #1;
      tok_valid = 1'b0; err_clr = 1'b0;
      rdy_k = 0; vld_k = 0; pushes = 0; pops = 0;
      for (int k = 1; k <= 20; k++) begin
         if (stk_push) pushes++;
         if (stk_pop) pops++;
         if (result_vld) vld_k = k;
         if (tok_ready) begin
            rdy_k = k;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   int rk, vk, pu, po;

   initial begin
      rst = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_op = 2'b00;
      tok_data = 4'h0; err_clr = 1'b0;

      //      i  op  fn     data  clr  res   dep eu eo rdy vld push pop
      setv( 0, 0, 2'd0, 4'h3, 0, 4'h0, 1, 0, 0, 2, 0, 1, 0);
      setv( 1, 0, 2'd0, 4'h5, 0, 4'h0, 2, 0, 0, 2, 0, 1, 0);
      setv( 2, 1, 2'd0, 4'h0, 0, 4'h8, 1, 0, 0, 7, 6, 1, 2);
      setv( 3, 0, 2'd0, 4'h3, 0, 4'h8, 2, 0, 0, 2, 0, 1, 0);
      setv( 4, 0, 2'd0, 4'h5, 0, 4'h8, 3, 0, 0, 2, 0, 1, 0);
      setv( 5, 1, 2'd1, 4'h0, 0, 4'hE, 2, 0, 0, 7, 6, 1, 2);
      setv( 6, 0, 2'd0, 4'h9, 0, 4'hE, 3, 0, 0, 2, 0, 1, 0);
      setv( 7, 0, 2'd0, 4'h9, 0, 4'hE, 4, 0, 0, 2, 0, 1, 0);
      setv( 8, 1, 2'd0, 4'h0, 0, 4'h2, 3, 0, 0, 7, 6, 1, 2);
      setv( 9, 0, 2'd0, 4'hC, 0, 4'h2, 4, 0, 0, 2, 0, 1, 0);
      setv(10, 0, 2'd0, 4'hA, 0, 4'h2, 5, 0, 0, 2, 0, 1, 0);
      setv(11, 1, 2'd2, 4'h0, 0, 4'h8, 4, 0, 0, 7, 6, 1, 2);
      setv(12, 0, 2'd0, 4'h6, 0, 4'h8, 5, 0, 0, 2, 0, 1, 0);
      setv(13, 1, 2'd3, 4'h0, 0, 4'hE, 4, 0, 0, 7, 6, 1, 2);
      setv(14, 1, 2'd2, 4'h0, 0, 4'h2, 3, 0, 0, 7, 6, 1, 2);
      setv(15, 1, 2'd3, 4'h0, 0, 4'hC, 2, 0, 0, 7, 6, 1, 2);
      setv(16, 1, 2'd1, 4'h0, 0, 4'hC, 1, 0, 0, 7, 6, 1, 2);
      setv(17, 1, 2'd0, 4'h0, 0, 4'hC, 1, 1, 0, 1, 0, 0, 0);
      setv(18, 0, 2'd0, 4'h1, 1, 4'hC, 2, 0, 0, 2, 0, 1, 0);
      setv(19, 0, 2'd0, 4'h2, 0, 4'hC, 3, 0, 0, 2, 0, 1, 0);
      setv(20, 0, 2'd0, 4'h3, 0, 4'hC, 4, 0, 0, 2, 0, 1, 0);
      setv(21, 0, 2'd0, 4'h4, 0, 4'hC, 5, 0, 0, 2, 0, 1, 0);
      setv(22, 0, 2'd0, 4'h5, 0, 4'hC, 6, 0, 0, 2, 0, 1, 0);
      setv(23, 0, 2'd0, 4'h6, 0, 4'hC, 7, 0, 0, 2, 0, 1, 0);
      setv(24, 0, 2'd0, 4'h7, 0, 4'hC, 8, 0, 0, 2, 0, 1, 0);
      setv(25, 0, 2'd0, 4'hF, 0, 4'hC, 8, 0, 1, 1, 0, 0, 0);
      setv(26, 0, 2'd0, 4'hF, 1, 4'hC, 8, 0, 1, 1, 0, 0, 0);
      setv(27, 1, 2'd0, 4'h0, 1, 4'hD, 7, 0, 0, 7, 6, 1, 2);
      setv(28, 1, 2'd0, 4'h0, 0, 4'h2, 6, 0, 0, 7, 6, 1, 2);
      setv(29, 1, 2'd3, 4'h0, 0, 4'h6, 5, 0, 0, 7, 6, 1, 2);

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_ready",  int'(tok_ready), 1);
      chk("reset_depth",  int'(depth), 0);
      chk("reset_result", int'(result), 0);
      chk("reset_strobes", int'({stk_push, stk_pop, result_vld}), 0);
      chk("reset_errs",   int'({err_under, err_over}), 0);

      for (int i = 0; i < 30; i++) begin
         run_tok(vt[i].is_op, vt[i].op, vt[i].data, vt[i].clr, rk, vk, pu, po);
         chk($sformatf("v%0d_ready_lat", i), rk, vt[i].e_rdy);
         chk($sformatf("v%0d_vld_lat", i), vk, vt[i].e_vld);
         chk($sformatf("v%0d_pushes", i), pu, vt[i].e_push);
         chk($sformatf("v%0d_pops", i), po, vt[i].e_pop);
         chk($sformatf("v%0d_result", i), int'(result), int'(vt[i].e_res));
         chk($sformatf("v%0d_depth", i), int'(depth), vt[i].e_depth);
         chk($sformatf("v%0d_err_under", i), int'(err_under), int'(vt[i].e_eu));
         chk($sformatf("v%0d_err_over", i), int'(err_over), int'(vt[i].e_eo));
      end

      // Reset while in CAP_A of an add: everything aborts, no strobes follow.
      tok_valid = 1'b1; tok_is_op = 1'b1; tok_op = 2'b00;
      @(posedge clk); #1;
      tok_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("cap_a_no_strobe", int'({stk_push, stk_pop}), 0);
      chk("cap_a_depth", int'(depth), 3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_ready",   int'(tok_ready), 1);
      chk("abort_depth",   int'(depth), 0);
      chk("abort_result",  int'(result), 0);
      chk("abort_strobes", int'({stk_push, stk_pop, result_vld}), 0);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         chk("abort_quiet", int'({stk_push, stk_pop, result_vld, tok_ready}), 1);
      end

      run_tok(1'b0, 2'd0, 4'h3, 1'b0, rk, vk, pu, po);
      run_tok(1'b0, 2'd0, 4'h5, 1'b0, rk, vk, pu, po);
      chk("post_rst_depth2", int'(depth), 2);
      run_tok(1'b1, 2'd0, 4'h0, 1'b0, rk, vk, pu, po);
      chk("post_rst_add_vld", vk, 6);
      chk("post_rst_add_rdy", rk, 7);
      chk("post_rst_add_res", int'(result), 8);
      chk("post_rst_depth1", int'(depth), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
